// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode values, instruction-length decode and the fetch FSM states.
// The HALTED state exists only when FETCH_HALT_EN is defined.
package cpu_pkg;

  localparam logic [7:0] OP_LDA_IMM = 8'h01;
  localparam logic [7:0] OP_LDB_IMM = 8'h02;
  localparam logic [7:0] OP_ADD_IMM = 8'h03;
  localparam logic [7:0] OP_SUB_IMM = 8'h04;
  localparam logic [7:0] OP_AND_IMM = 8'h05;
  localparam logic [7:0] OP_INCA    = 8'h0B;
  localparam logic [7:0] OP_JMP     = 8'h14;
  localparam logic [7:0] OP_JZ      = 8'h15;
  localparam logic [7:0] OP_JNZ     = 8'h16;
  localparam logic [7:0] OP_HALT    = 8'hFF;

  typedef enum logic [2:0] {
    ISSUE    = 3'd0,
    OPC_WAIT = 3'd1,
    OPR_WAIT = 3'd2,
    VALID    = 3'd3
`ifdef FETCH_HALT_EN
    , HALTED = 3'd4
`endif
  } fetch_state_e;

  function automatic logic is_two_byte(input logic [7:0] opcode);
    logic two_byte;
    case (opcode)
      OP_LDA_IMM, OP_LDB_IMM, OP_ADD_IMM, OP_SUB_IMM, OP_AND_IMM,
      OP_JMP, OP_JZ, OP_JNZ: two_byte = 1'b1;
      default:               two_byte = 1'b0;
    endcase
    return two_byte;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Bundle between the fetch unit, the program ROM, the decoder and the execute-stage redirect.
// master = fetch unit side, slave = ROM/decoder/execute side.
interface instruction_fetch_unit_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] romAddress;
  logic [DATA_W-1:0] romData;
  logic              instrValid;
  logic              instrReady;
  logic [DATA_W-1:0] instrOpcode;
  logic [DATA_W-1:0] instrOperand;
  logic              instrTwoByte;
  logic [ADDR_W-1:0] instrPc;
  logic              redirectValid;
  logic [ADDR_W-1:0] redirectAddr;
  logic              halted;

  modport master (
    output romAddress, instrValid, instrOpcode, instrOperand, instrTwoByte, instrPc, halted,
    input  romData, instrReady, redirectValid, redirectAddr
  );

  modport slave (
    input  romAddress, instrValid, instrOpcode, instrOperand, instrTwoByte, instrPc, halted,
    output romData, instrReady, redirectValid, redirectAddr
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Program-ROM fetch sequencer: PC, opcode/operand fetch, valid/ready issue and redirect flush.
// Optional FETCH_HALT_EN stops fetch on opcode 8'hFF until a redirect or reset.
module instruction_fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W       = 8,
  parameter int                DATA_W       = 8,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = 8'h00
) (
  input  logic                      clk,
  input  logic                      resetN,
  instruction_fetch_unit_if.master  bus
);

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_inc_d;
  logic [ADDR_W-1:0] pc_prev_d;
  logic              valid_q;
  logic [DATA_W-1:0] opcode_q;
  logic [DATA_W-1:0] operand_q;
  logic              two_byte_q;
  logic [ADDR_W-1:0] instr_pc_q;

  assign pc_inc_d  = pc_q + ADDR_W'(1);
  assign pc_prev_d = pc_q - ADDR_W'(1);

  assign bus.romAddress   = pc_q;
  assign bus.instrValid   = valid_q;
  assign bus.instrOpcode  = opcode_q;
  assign bus.instrOperand = operand_q;
  assign bus.instrTwoByte = two_byte_q;
  assign bus.instrPc      = instr_pc_q;

`ifdef FETCH_HALT_EN
  logic halted_q;
  assign bus.halted = halted_q;
`else
  assign bus.halted = 1'b0;
`endif

  // Fetch FSM; redirect outranks everything and discards whatever the ROM returns next.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= ISSUE;
      pc_q       <= RESET_VECTOR;
      valid_q    <= 1'b0;
      opcode_q   <= '0;
      operand_q  <= '0;
      two_byte_q <= 1'b0;
      instr_pc_q <= '0;
`ifdef FETCH_HALT_EN
      halted_q   <= 1'b0;
`endif
    end else if (bus.redirectValid) begin
      state_q <= ISSUE;
      pc_q    <= bus.redirectAddr;
      valid_q <= 1'b0;
`ifdef FETCH_HALT_EN
      halted_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        ISSUE: begin
          pc_q    <= pc_inc_d;
          state_q <= OPC_WAIT;
        end
        OPC_WAIT: begin
`ifdef FETCH_HALT_EN
          if (bus.romData == OP_HALT) begin
            state_q  <= HALTED;
            halted_q <= 1'b1;
          end else
`endif
          begin
            opcode_q   <= bus.romData;
            instr_pc_q <= pc_prev_d;
            two_byte_q <= is_two_byte(bus.romData);
            if (is_two_byte(bus.romData)) begin
              pc_q    <= pc_inc_d;
              state_q <= OPR_WAIT;
            end else begin
              operand_q <= '0;
              valid_q   <= 1'b1;
              state_q   <= VALID;
            end
          end
        end
        OPR_WAIT: begin
          operand_q <= bus.romData;
          valid_q   <= 1'b1;
          state_q   <= VALID;
        end
        VALID: begin
          // ROM is already reading pc, so acceptance overlaps the next opcode fetch.
          if (bus.instrReady) begin
            pc_q    <= pc_inc_d;
            valid_q <= 1'b0;
            state_q <= OPC_WAIT;
          end else begin
            state_q <= VALID;
          end
        end
`ifdef FETCH_HALT_EN
        HALTED: begin
          valid_q <= 1'b0;
          state_q <= HALTED;
        end
`endif
        default: begin
          valid_q <= 1'b0;
          state_q <= ISSUE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a registered-read ROM model.
// Expectations for 8'hFF follow FETCH_HALT_EN when the bench is built with it.
module tb_instruction_fetch_unit;

  logic clk;
  logic resetN;
  logic [7:0] mem [0:255];
  int vectors;
  int miscompares;

  instruction_fetch_unit_if #(.ADDR_W(8), .DATA_W(8)) bif ();

  instruction_fetch_unit #(
    .ADDR_W(8), .DATA_W(8), .RESET_VECTOR(8'h00)
  ) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM with one-cycle registered read
  always @(posedge clk) bif.romData <= mem[bif.romAddress];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_rom(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = b0;
    mem[1] = b1;
    mem[2] = b2;
  endtask

  task automatic do_reset(input logic ready);
    resetN            = 1'b0;
    bif.redirectValid = 1'b0;
    bif.redirectAddr  = 8'h00;
    bif.instrReady    = ready;
    tick();
    tick();
    resetN = 1'b1;
  endtask

  task automatic wait_valid(input int max_cycles, input string tag);
    int n;
    n = 0;
    while (bif.instrValid !== 1'b1 && n < max_cycles) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, bif.instrValid}, 32'd1);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;

    // Reset state
    load_rom(8'h01, 8'hAA, 8'h0B);
    do_reset(1'b1);
    resetN = 1'b0;
    tick();
    chk("rst_valid",   {31'd0, bif.instrValid},   32'd0);
    chk("rst_opcode",  {24'd0, bif.instrOpcode},  32'd0);
    chk("rst_operand", {24'd0, bif.instrOperand}, 32'd0);
    chk("rst_twobyte", {31'd0, bif.instrTwoByte}, 32'd0);
    chk("rst_pc",      {24'd0, bif.instrPc},      32'd0);
    chk("rst_halted",  {31'd0, bif.halted},       32'd0);
    chk("rst_romaddr", {24'd0, bif.romAddress},   32'd0);
    resetN = 1'b1;

    // 1: two-byte then one-byte, ready held high
    tick();
    chk("t1_lat_c1", {31'd0, bif.instrValid}, 32'd0);
    tick();
    chk("t1_lat_c2", {31'd0, bif.instrValid}, 32'd0);
    tick();
    chk("t1_valid0", {31'd0, bif.instrValid},   32'd1);
    chk("t1_op0",    {24'd0, bif.instrOpcode},  32'h01);
    chk("t1_opr0",   {24'd0, bif.instrOperand}, 32'hAA);
    chk("t1_pc0",    {24'd0, bif.instrPc},      32'h00);
    chk("t1_two0",   {31'd0, bif.instrTwoByte}, 32'd1);
    tick();
    chk("t1_gap", {31'd0, bif.instrValid}, 32'd0);
    tick();
    chk("t1_valid1", {31'd0, bif.instrValid},   32'd1);
    chk("t1_op1",    {24'd0, bif.instrOpcode},  32'h0B);
    chk("t1_opr1",   {24'd0, bif.instrOperand}, 32'h00);
    chk("t1_pc1",    {24'd0, bif.instrPc},      32'h02);
    chk("t1_two1",   {31'd0, bif.instrTwoByte}, 32'd0);

    // 2: one-byte stream, valid every other cycle
    load_rom(8'h0B, 8'h0B, 8'h0B);
    do_reset(1'b1);
    for (int c = 1; c <= 6; c++) begin
      tick();
      chk($sformatf("t2_valid_c%0d", c), {31'd0, bif.instrValid}, (c % 2 == 0) ? 32'd1 : 32'd0);
      if (c % 2 == 0)
        chk($sformatf("t2_pc_c%0d", c), {24'd0, bif.instrPc}, 32'(c / 2 - 1));
    end

    // 3: backpressure holds outputs and romAddress
    load_rom(8'h01, 8'hAA, 8'h00);
    do_reset(1'b0);
    tick(); tick(); tick();
    for (int c = 0; c < 5; c++) begin
      chk("t3_hold_valid", {31'd0, bif.instrValid},   32'd1);
      chk("t3_hold_op",    {24'd0, bif.instrOpcode},  32'h01);
      chk("t3_hold_opr",   {24'd0, bif.instrOperand}, 32'hAA);
      chk("t3_hold_addr",  {24'd0, bif.romAddress},   32'h02);
      tick();
    end
    bif.instrReady = 1'b1;
    tick();
    bif.instrReady = 1'b0;
    chk("t3_accept_once", {31'd0, bif.instrValid}, 32'd0);
    chk("t3_addr_next",   {24'd0, bif.romAddress}, 32'h03);
    tick();
    chk("t3_next_valid", {31'd0, bif.instrValid}, 32'd1);
    chk("t3_next_pc",    {24'd0, bif.instrPc},    32'h02);

    // 4: redirect during OPR_WAIT of 02 0F
    load_rom(8'h02, 8'h0F, 8'h00);
    mem[8'h10] = 8'h0B;
    do_reset(1'b1);
    tick(); tick();
    bif.redirectValid = 1'b1;
    bif.redirectAddr  = 8'h10;
    tick();
    bif.redirectValid = 1'b0;
    chk("t4_flush_valid", {31'd0, bif.instrValid}, 32'd0);
    chk("t4_flush_addr",  {24'd0, bif.romAddress}, 32'h10);
    tick();
    chk("t4_no_old", {31'd0, bif.instrValid}, 32'd0);
    wait_valid(5, "t4_wait");
    chk("t4_pc", {24'd0, bif.instrPc},     32'h10);
    chk("t4_op", {24'd0, bif.instrOpcode}, 32'h0B);

    // 5: two-byte opcode at FF wraps to 00 for its operand
    load_rom(8'h55, 8'h0B, 8'h00);
    mem[8'hFF] = 8'h01;
    do_reset(1'b0);
    bif.redirectValid = 1'b1;
    bif.redirectAddr  = 8'hFF;
    tick();
    bif.redirectValid = 1'b0;
    wait_valid(6, "t5_wait");
    chk("t5_op",   {24'd0, bif.instrOpcode},  32'h01);
    chk("t5_opr",  {24'd0, bif.instrOperand}, 32'h55);
    chk("t5_pc",   {24'd0, bif.instrPc},      32'hFF);
    chk("t5_addr", {24'd0, bif.romAddress},   32'h01);
    bif.instrReady = 1'b1;
    tick();
    tick();
    chk("t5_next_valid", {31'd0, bif.instrValid},  32'd1);
    chk("t5_next_pc",    {24'd0, bif.instrPc},     32'h01);
    chk("t5_next_op",    {24'd0, bif.instrOpcode}, 32'h0B);

    // 6: opcode FF after a one-byte instruction
    load_rom(8'h0B, 8'hFF, 8'h00);
    do_reset(1'b1);
    tick(); tick();
    chk("t6_first_pc", {24'd0, bif.instrPc}, 32'h00);
    tick(); tick();
`ifdef FETCH_HALT_EN
    chk("t6_halted", {31'd0, bif.halted},     32'd1);
    chk("t6_novalid", {31'd0, bif.instrValid}, 32'd0);
    tick(); tick(); tick();
    chk("t6_still_halted", {31'd0, bif.halted},     32'd1);
    chk("t6_still_novld",  {31'd0, bif.instrValid}, 32'd0);
    bif.redirectValid = 1'b1;
    bif.redirectAddr  = 8'h00;
    tick();
    bif.redirectValid = 1'b0;
    chk("t6_unhalt", {31'd0, bif.halted}, 32'd0);
    wait_valid(5, "t6_restart");
    chk("t6_restart_pc", {24'd0, bif.instrPc}, 32'h00);
`else
    chk("t6_ff_valid", {31'd0, bif.instrValid},  32'd1);
    chk("t6_ff_op",    {24'd0, bif.instrOpcode}, 32'hFF);
    chk("t6_ff_pc",    {24'd0, bif.instrPc},     32'h01);
    chk("t6_ff_two",   {31'd0, bif.instrTwoByte}, 32'd0);
    chk("t6_halted0",  {31'd0, bif.halted},      32'd0);
`endif

    // 7: async reset while VALID, then refetch from the reset vector
    load_rom(8'h0B, 8'h0B, 8'h0B);
    do_reset(1'b0);
    tick(); tick(); tick();
    chk("t7_in_valid", {31'd0, bif.instrValid}, 32'd1);
    chk("t7_pc_before", {24'd0, bif.instrPc},   32'h00);
    #1;
    resetN = 1'b0;
    #1;
    chk("t7_async_valid", {31'd0, bif.instrValid}, 32'd0);
    chk("t7_async_addr",  {24'd0, bif.romAddress}, 32'h00);
    tick();
    resetN = 1'b1;
    bif.instrReady = 1'b1;
    wait_valid(5, "t7_refetch");
    chk("t7_refetch_pc", {24'd0, bif.instrPc}, 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
